// File: rtl/redundancy_mode_ctrl.sv
// Redundancy mode controller: routes the traffic of three cores onto one bus
// port by majority vote (TMR), pairwise compare (DMR) or core-0 pass-through
// (INDEP). It also runs the unload/reload resynchronisation FSM with a
// watchdog and a setback pulse, and keeps per-core mismatch counters.

// Per-core comparator: flags a core whose main vector differs from the
// reference, or whose data vector differs while the reference requests data.
module redundancy_mode_ctrl_cmp #(
  parameter int unsigned MainWidth = 40,
  parameter int unsigned DataWidth = 69
) (
  input  logic [MainWidth-1:0] main_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [MainWidth-1:0] ref_main_i,
  input  logic [DataWidth-1:0] ref_data_i,
  output logic                 differ_o
);
  assign differ_o = (main_i != ref_main_i) |
                    (ref_main_i[0] & (data_i != ref_data_i));
endmodule

module redundancy_mode_ctrl #(
  parameter int unsigned MainWidth     = 40,
  parameter int unsigned DataWidth     = 69,
  parameter int unsigned CntWidth      = 8,
  parameter int unsigned TimeoutCycles = 1024,
  parameter int unsigned SetbackCycles = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [1:0]                    mode_i,
  input  logic                          fetch_en_i,
  input  logic                          force_resynch_i,
  input  logic                          unload_done_i,
  input  logic                          reload_done_i,
  input  logic                          clr_cnt_i,
  input  logic [2:0][MainWidth-1:0]     core_main_i,
  input  logic [2:0][DataWidth-1:0]     core_data_i,
  output logic [MainWidth-1:0]          bus_main_o,
  output logic [DataWidth-1:0]          bus_data_o,
  output logic                          mismatch_o,
  output logic [2:0]                    faulty_core_o,
  output logic                          resynch_req_o,
  output logic [2:0]                    setback_o,
  output logic [1:0]                    state_o,
  output logic                          timeout_o,
  output logic [2:0][CntWidth-1:0]      mismatch_cnt_o
);

  localparam int unsigned NumCores = 3;
  localparam int unsigned WdW      = $clog2(TimeoutCycles);
  localparam int unsigned SbW      = $clog2(SetbackCycles + 1);

  typedef enum logic [1:0] {RUN = 2'd0, UNLOAD = 2'd1, RELOAD = 2'd2, SETBACK = 2'd3} state_e;
  typedef enum logic [1:0] {MODE_TMR = 2'd0, MODE_DMR = 2'd1, MODE_INDEP = 2'd2, MODE_RSVD = 2'd3} mode_e;

  typedef struct packed {
    logic [MainWidth-1:0] main;
    logic [DataWidth-1:0] data;
  } core_t;

  state_e                              state_q, state_d;
  mode_e                               mode_q, mode_d, mode_eff;
  logic [2:0]                          mask_q, mask_d;
  logic [WdW-1:0]                      wd_q, wd_d;
  logic [2:0]                          setback_q, setback_d;
  logic [SbW-1:0]                      sbc_q, sbc_d;
  logic                                timeout_q, timeout_d;
  logic [NumCores-1:0][CntWidth-1:0]   cnt_q, cnt_d;

  core_t                               vote;
  logic [NumCores-1:0]                 tmr_diff;
  logic                                dmr_diff;
  logic                                wd_exp;

  // Mode is live while running and frozen for the rest of a resync.
  assign mode_eff = (state_q == RUN) ? mode_e'(mode_i) : mode_q;

  // Bitwise 2-of-3 majority over both vectors.
  assign vote.main = (core_main_i[0] & core_main_i[1]) |
                     (core_main_i[0] & core_main_i[2]) |
                     (core_main_i[1] & core_main_i[2]);
  assign vote.data = (core_data_i[0] & core_data_i[1]) |
                     (core_data_i[0] & core_data_i[2]) |
                     (core_data_i[1] & core_data_i[2]);

  for (genvar g = 0; g < NumCores; g++) begin : g_tmr_cmp
    redundancy_mode_ctrl_cmp #(.MainWidth(MainWidth), .DataWidth(DataWidth)) u_cmp (
      .main_i     (core_main_i[g]),
      .data_i     (core_data_i[g]),
      .ref_main_i (vote.main),
      .ref_data_i (vote.data),
      .differ_o   (tmr_diff[g])
    );
  end

  // DMR pair compare: core 1 against core 0.
  redundancy_mode_ctrl_cmp #(.MainWidth(MainWidth), .DataWidth(DataWidth)) u_dmr_cmp (
    .main_i     (core_main_i[1]),
    .data_i     (core_data_i[1]),
    .ref_main_i (core_main_i[0]),
    .ref_data_i (core_data_i[0]),
    .differ_o   (dmr_diff)
  );

  // Bus selection and fault reporting for the active mode.
  always_comb begin
    bus_main_o    = core_main_i[0];
    bus_data_o    = core_data_i[0];
    faulty_core_o = '0;
    case (mode_eff)
      MODE_DMR: begin
        // A disagreeing pair must not issue any request to the bus.
        if (dmr_diff) begin
          bus_main_o    = '0;
          faulty_core_o = 3'b011;
        end
      end
      MODE_INDEP: ;
      default: begin
        bus_main_o    = vote.main;
        bus_data_o    = vote.data;
        faulty_core_o = tmr_diff;
      end
    endcase
  end

  assign mismatch_o     = |faulty_core_o;
  assign resynch_req_o  = mismatch_o & (state_q == RUN);
  assign setback_o      = setback_q;
  assign state_o        = state_q;
  assign timeout_o      = timeout_q;
  assign mismatch_cnt_o = cnt_q;

  // Saturating per-core mismatch counters; clear beats increment.
  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NumCores; i++) begin
      if (clr_cnt_i) begin
        cnt_d[i] = '0;
      end else if ((state_q == RUN) && faulty_core_o[i] && (cnt_q[i] != '1)) begin
        cnt_d[i] = cnt_q[i] + CntWidth'(1);
      end
    end
  end

  assign wd_exp = (wd_q == WdW'(TimeoutCycles - 1));

  // Resync FSM next state, watchdog and setback pulse timing.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    mask_d    = mask_q;
    wd_d      = wd_q;
    setback_d = setback_q;
    sbc_d     = sbc_q;
    timeout_d = 1'b0;

    // A running setback pulse counts down independently of the state.
    if (setback_q != '0) begin
      if (sbc_q != '0) sbc_d = sbc_q - SbW'(1);
      else             setback_d = '0;
    end

    case (state_q)
      RUN: begin
        mode_d = mode_e'(mode_i);
        if (mismatch_o | force_resynch_i) begin
          state_d = UNLOAD;
          mask_d  = faulty_core_o;  // zero for a purely forced resync
          wd_d    = '0;
        end
      end
      UNLOAD: begin
        if (unload_done_i) begin
          state_d   = RELOAD;
          wd_d      = '0;
          setback_d = mask_q;
          sbc_d     = SbW'(SetbackCycles - 1);
        end else if (wd_exp) begin
          state_d   = SETBACK;
          timeout_d = 1'b1;
          setback_d = 3'b111;
          sbc_d     = SbW'(SetbackCycles - 1);
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      RELOAD: begin
        if (reload_done_i) begin
          state_d = RUN;
        end else if (wd_exp) begin
          state_d   = SETBACK;
          timeout_d = 1'b1;
          setback_d = 3'b111;
          sbc_d     = SbW'(SetbackCycles - 1);
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      SETBACK: begin
        if (sbc_q == '0) state_d = RUN;
      end
    endcase

    // Fetch disable parks the FSM and truncates any pulse.
    if (!fetch_en_i) begin
      state_d   = RUN;
      wd_d      = '0;
      setback_d = '0;
      sbc_d     = '0;
      timeout_d = 1'b0;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RUN;
      mode_q    <= MODE_TMR;
      mask_q    <= '0;
      wd_q      <= '0;
      setback_q <= '0;
      sbc_q     <= '0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      mask_q    <= mask_d;
      wd_q      <= wd_d;
      setback_q <= setback_d;
      sbc_q     <= sbc_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_redundancy_mode_ctrl.sv
// Scoreboard bench for redundancy_mode_ctrl: a driver applies one stimulus per
// cycle and pushes the reference model's expectation; a monitor pops and
// compares on the falling edge.
module tb_redundancy_mode_ctrl;
  localparam int MW = 40, DW = 69, CW = 2, TO = 16, SB = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic [1:0] mode_i;
  logic fetch_en_i, force_resynch_i, unload_done_i, reload_done_i, clr_cnt_i;
  logic [2:0][MW-1:0] core_main_i;
  logic [2:0][DW-1:0] core_data_i;
  logic [MW-1:0] bus_main_o;
  logic [DW-1:0] bus_data_o;
  logic mismatch_o, resynch_req_o, timeout_o;
  logic [2:0] faulty_core_o, setback_o;
  logic [1:0] state_o;
  logic [2:0][CW-1:0] mismatch_cnt_o;

  always #5 clk_i = ~clk_i;

  redundancy_mode_ctrl #(.MainWidth(MW), .DataWidth(DW), .CntWidth(CW),
                         .TimeoutCycles(TO), .SetbackCycles(SB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .mode_i(mode_i), .fetch_en_i(fetch_en_i),
    .force_resynch_i(force_resynch_i), .unload_done_i(unload_done_i),
    .reload_done_i(reload_done_i), .clr_cnt_i(clr_cnt_i),
    .core_main_i(core_main_i), .core_data_i(core_data_i),
    .bus_main_o(bus_main_o), .bus_data_o(bus_data_o), .mismatch_o(mismatch_o),
    .faulty_core_o(faulty_core_o), .resynch_req_o(resynch_req_o),
    .setback_o(setback_o), .state_o(state_o), .timeout_o(timeout_o),
    .mismatch_cnt_o(mismatch_cnt_o));

  typedef struct {
    logic rst; logic [1:0] mode; logic fe, fr, ud, rd, clr;
    logic [2:0][MW-1:0] main; logic [2:0][DW-1:0] data;
  } stim_t;

  typedef struct {
    logic [MW-1:0] bm; logic [DW-1:0] bd; logic mm; logic [2:0] fc; logic rr;
    logic [2:0] sb; logic [1:0] st; logic to; logic [2:0][CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0;

  // Reference model state (behavioural view of the controller)
  int m_st, m_wd, m_sbl, m_mode;
  logic [2:0] m_sbv, m_mask;
  logic m_to;
  int m_cnt[3];

  task automatic model_reset();
    m_st = 0; m_wd = 0; m_sbl = 0; m_mode = 0; m_sbv = '0; m_mask = '0; m_to = 1'b0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  task automatic model_comb(output exp_t e);
    int md, votes;
    logic [MW-1:0] maj_m;
    logic [DW-1:0] maj_d;
    md = (m_st == 0) ? int'(mode_i) : m_mode;
    e.bm = core_main_i[0]; e.bd = core_data_i[0]; e.fc = '0;
    if (md == 1) begin
      if (core_main_i[0] != core_main_i[1] ||
          (core_main_i[0][0] && core_data_i[0] != core_data_i[1])) begin
        e.bm = '0; e.fc = 3'b011;
      end
    end else if (md != 2) begin
      for (int b = 0; b < MW; b++) begin
        votes = int'(core_main_i[0][b]) + int'(core_main_i[1][b]) + int'(core_main_i[2][b]);
        maj_m[b] = (votes >= 2);
      end
      for (int b = 0; b < DW; b++) begin
        votes = int'(core_data_i[0][b]) + int'(core_data_i[1][b]) + int'(core_data_i[2][b]);
        maj_d[b] = (votes >= 2);
      end
      e.bm = maj_m; e.bd = maj_d;
      for (int i = 0; i < 3; i++)
        e.fc[i] = (core_main_i[i] != maj_m) || (maj_m[0] && core_data_i[i] != maj_d);
    end
    e.mm = |e.fc;
    e.rr = e.mm && (m_st == 0);
    e.sb = (m_sbl > 0) ? m_sbv : 3'b000;
    e.st = 2'(m_st);
    e.to = m_to;
    for (int i = 0; i < 3; i++) e.cnt[i] = CW'(m_cnt[i]);
  endtask

  task automatic model_step(input exp_t e);
    int nst;
    logic nto;
    nst = m_st; nto = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (clr_cnt_i) m_cnt[i] = 0;
      else if (m_st == 0 && e.fc[i] && m_cnt[i] < CMAX) m_cnt[i]++;
    end
    if (m_st == 0) m_mode = int'(mode_i);
    if (m_sbl > 0) m_sbl--;
    case (m_st)
      0: if (e.mm || force_resynch_i) begin nst = 1; m_mask = e.fc; m_wd = 0; end
      1: if (unload_done_i) begin nst = 2; m_wd = 0; m_sbv = m_mask; m_sbl = SB; end
         else if (m_wd == TO - 1) begin nst = 3; nto = 1'b1; m_sbv = 3'b111; m_sbl = SB; end
         else m_wd++;
      2: if (reload_done_i) nst = 0;
         else if (m_wd == TO - 1) begin nst = 3; nto = 1'b1; m_sbv = 3'b111; m_sbl = SB; end
         else m_wd++;
      default: if (m_sbl == 0) nst = 0;
    endcase
    if (!fetch_en_i) begin nst = 0; m_sbl = 0; nto = 1'b0; m_wd = 0; end
    m_st = nst; m_to = nto;
  endtask

  // Driver: apply one stimulus, record the expectation, advance the model.
  task automatic cyc(input stim_t s);
    exp_t e;
    @(posedge clk_i); #1;
    rst_ni = s.rst; mode_i = s.mode; fetch_en_i = s.fe; force_resynch_i = s.fr;
    unload_done_i = s.ud; reload_done_i = s.rd; clr_cnt_i = s.clr;
    core_main_i = s.main; core_data_i = s.data;
    if (!s.rst) model_reset();
    model_comb(e);
    q.push_back(e);
    if (s.rst) model_step(e);
  endtask

  function automatic stim_t clean(input logic [1:0] md);
    stim_t s;
    logic [MW-1:0] m;
    logic [DW-1:0] d;
    m = MW'({$urandom(), $urandom()});
    d = DW'({$urandom(), $urandom(), $urandom()});
    s.rst = 1'b1; s.mode = md; s.fe = 1'b1; s.fr = 1'b0; s.ud = 1'b0; s.rd = 1'b0; s.clr = 1'b0;
    for (int i = 0; i < 3; i++) begin s.main[i] = m; s.data[i] = d; end
    return s;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(clean(2'd0));
  endtask

  task automatic unload_reload();
    stim_t s;
    s = clean(2'd0); s.ud = 1'b1; cyc(s);
    s = clean(2'd0); s.rd = 1'b1; cyc(s);
  endtask

  task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
  endtask

  // Monitor: compare the DUT against the oldest queued expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("bus_main", 128'(bus_main_o), 128'(e.bm));
      chk("bus_data", 128'(bus_data_o), 128'(e.bd));
      chk("mismatch", 128'(mismatch_o), 128'(e.mm));
      chk("faulty", 128'(faulty_core_o), 128'(e.fc));
      chk("resynch_req", 128'(resynch_req_o), 128'(e.rr));
      chk("setback", 128'(setback_o), 128'(e.sb));
      chk("state", 128'(state_o), 128'(e.st));
      chk("timeout", 128'(timeout_o), 128'(e.to));
      chk("mismatch_cnt", 128'(mismatch_cnt_o), 128'(e.cnt));
    end
  end

  initial begin
    stim_t s;
    int c, k;
    rst_ni = 1'b0; mode_i = '0; fetch_en_i = 1'b1; force_resynch_i = 1'b0;
    unload_done_i = 1'b0; reload_done_i = 1'b0; clr_cnt_i = 1'b0;
    core_main_i = '0; core_data_i = '0;
    model_reset();
    s = clean(2'd0); s.rst = 1'b0; cyc(s); cyc(s);
    idle(2);

    // TMR single bit flip on core 1
    s = clean(2'd0); s.main[1][5] = ~s.main[1][5]; cyc(s);
    idle(1); unload_reload(); idle(5);

    // Data difference on core 2: masked when bit 0 is clear, flagged when set
    s = clean(2'd0); s.main[0][0] = 1'b0; s.main[1][0] = 1'b0; s.main[2][0] = 1'b0;
    s.data[2][17] = ~s.data[2][17]; cyc(s);
    s = clean(2'd0); s.main[0][0] = 1'b1; s.main[1][0] = 1'b1; s.main[2][0] = 1'b1;
    s.data[2][60] = ~s.data[2][60]; cyc(s);
    unload_reload(); idle(5);

    // DMR: disagreeing pair, then core 2 garbage with an agreeing pair
    s = clean(2'd1); s.main[1][9] = ~s.main[1][9]; cyc(s);
    s = clean(2'd0); cyc(s);
    unload_reload();
    s = clean(2'd1); s.main[2] = ~s.main[2]; s.data[2] = ~s.data[2]; cyc(s);
    s = clean(2'd2); s.main[1] = ~s.main[1]; cyc(s);
    idle(5);

    // Full resync on core 0 fault with delayed reload
    s = clean(2'd0); s.main[0][3] = ~s.main[0][3]; cyc(s);
    idle(1);
    s = clean(2'd0); s.ud = 1'b1; cyc(s);
    idle(10);
    s = clean(2'd0); s.rd = 1'b1; cyc(s);
    idle(4);

    // Watchdog in UNLOAD and in RELOAD
    s = clean(2'd0); s.fr = 1'b1; cyc(s);
    idle(24);
    s = clean(2'd0); s.main[2][1] = ~s.main[2][1]; cyc(s);
    s = clean(2'd0); s.ud = 1'b1; cyc(s);
    idle(24);

    // Counter saturation on core 2, then clear together with a mismatch
    for (int i = 0; i < 5; i++) begin
      s = clean(2'd0); s.data[2] = ~s.data[2]; s.main[0][0] = 1'b1;
      s.main[1][0] = 1'b1; s.main[2][0] = 1'b1; cyc(s);
      unload_reload();
    end
    s = clean(2'd0); s.main[2][7] = ~s.main[2][7]; s.clr = 1'b1; cyc(s);
    unload_reload(); idle(2);

    // Fetch disable in RELOAD and during a SETBACK pulse
    s = clean(2'd0); s.main[1][0] = ~s.main[1][0]; cyc(s);
    s = clean(2'd0); s.ud = 1'b1; cyc(s);
    idle(1);
    s = clean(2'd0); s.fe = 1'b0; cyc(s);
    idle(3);
    s = clean(2'd0); s.fr = 1'b1; cyc(s);
    idle(TO + 1);
    s = clean(2'd0); s.fe = 1'b0; cyc(s);
    idle(3);

    // Reset while a setback pulse is running in RELOAD
    s = clean(2'd0); s.main[0][2] = ~s.main[0][2]; cyc(s);
    s = clean(2'd0); s.ud = 1'b1; cyc(s);
    s = clean(2'd0); s.rst = 1'b0; cyc(s);
    idle(3);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      s = clean(2'($urandom_range(0, 3)));
      k = $urandom_range(0, 9);
      c = $urandom_range(0, 2);
      if (k < 3) begin
        s.main[c][$urandom_range(0, MW - 1)] ^= 1'b1;
      end else if (k < 5) begin
        s.data[c][$urandom_range(0, DW - 1)] ^= 1'b1;
        if (k == 4) begin s.main[0][0] = 1'b1; s.main[1][0] = 1'b1; s.main[2][0] = 1'b1; end
      end else if (k == 5) begin
        s.main[c] = MW'({$urandom(), $urandom()});
        s.main[(c + 1) % 3][$urandom_range(0, MW - 1)] ^= 1'b1;
      end
      s.fr  = ($urandom_range(0, 19) == 0);
      s.ud  = ($urandom_range(0, 7) == 0);
      s.rd  = ($urandom_range(0, 7) == 0);
      s.clr = ($urandom_range(0, 49) == 0);
      s.fe  = ($urandom_range(0, 39) != 0);
      s.rst = ($urandom_range(0, 499) != 0);
      cyc(s);
    end

    repeat (3) @(posedge clk_i);
    chk("scoreboard_drained", 128'(q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
